niosii_cpu_ocimem_ctrl: RTL and testbench
=========================================

Name: niosii_cpu_ocimem_ctrl

Overview:
Debug-memory access controller sitting directly downstream of the CPU debug-slave wrapper, in the sysclk domain.
- Consumes jdo and the take_*_ocimem_* strobes; performs reads and writes on the on-chip debug RAM.
- Returns MonDReg, monitor_ready and monitor_error to the debug-slave tck side.
- Arbitrates a CPU-side Avalon-MM slave port onto the same single-port RAM; debug requests always win.

Parameters:
ADDR_W, 8, debug RAM word-address width (256 x 32-bit words)

Ports:
clk  in  1  system clock; sole clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  debug command/data word from the debug-slave sysclk stage
take_action_ocimem_a  in  1  1-cycle pulse: load address (optionally read, optionally clear error)
take_no_action_ocimem_a  in  1  1-cycle pulse: read at current address
take_action_ocimem_b  in  1  1-cycle pulse: write jdo data at current address
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte enables
avs_readdata  out  32  CPU read data, valid when avs_read & !avs_waitrequest
avs_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  RAM word address
ram_wr  out  1  RAM write strobe
ram_be  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, registered inside the RAM, 1-cycle latency
MonAReg  out  ADDR_W  current debug address
MonDReg  out  32  last debug read data
monitor_ready  out  1  debug operation complete
monitor_error  out  1  sticky overrun/collision flag

Behaviour:
Reset (asynchronous, reset_n=0):
- State IDLE; pending request cleared.
- MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0.
- ram_wr=0, avs_waitrequest=1 (forced high while reset_n=0).
- Reset mid-operation aborts it; no RAM write is issued after reset.

jdo fields:
- addr = jdo[17 +: ADDR_W]
- read-request = jdo[34]
- error-clear = jdo[35]
- write data = jdo[34:3]

Strobe capture:
- take_action_ocimem_a: MonAReg <= addr next edge; if jdo[35], monitor_error <= 0; if jdo[34], queue a read.
- take_no_action_ocimem_a: queue a read at MonAReg.
- take_action_ocimem_b: queue a write of jdo[34:3], be=4'hF.
- Any queued op clears monitor_ready on the capture edge.
- Strobe while a debug op is pending or in DBG_RD_WAIT: request dropped, monitor_error <= 1, MonAReg unchanged.
- More than one strobe in the same cycle: priority a > b > no_action_a; the others are dropped and monitor_error <= 1.

FSM states: IDLE, DBG_RD_WAIT, CPU_RD_WAIT.
IDLE, debug pending (priority):
- Write: ram_wr=1, ram_addr=MonAReg in that cycle. Next edge: monitor_ready <= 1, MonAReg increments, pending clears. Stay IDLE.
- Read: ram_addr=MonAReg in that cycle; go to DBG_RD_WAIT.
IDLE, no debug pending:
- avs_write: ram_wr=1, ram_be=avs_byteenable, avs_waitrequest=0 in the same cycle.
- avs_read: drive ram_addr=avs_address, keep waitrequest=1, go to CPU_RD_WAIT.
DBG_RD_WAIT:
- MonDReg <= ram_rdata, monitor_ready <= 1, MonAReg increments, go to IDLE.
CPU_RD_WAIT:
- avs_readdata = ram_rdata, avs_waitrequest=0, go to IDLE.
- CPU read latency is 2 cycles minimum.

Starvation and waiting:
- A pending debug op stalls the CPU (waitrequest=1) until it completes.
- A CPU read already in CPU_RD_WAIT always completes first; the debug op then waits one cycle.

Arithmetic:
- MonAReg increments modulo 2^ADDR_W; all-ones wraps to 0 silently.

Optional Feature:
OCIMEM_AUTOINC_EN
- Defined: MonAReg increments after every completed debug read or write.
- Undefined: MonAReg changes only on take_action_ocimem_a.
- All other behaviour is identical in both builds.

Decomposition:
Shared package niosii_ocimem_pkg holds:
- the state enum (IDLE, DBG_RD_WAIT, CPU_RD_WAIT)
- JDO_ADDR_LSB=17, JDO_RDREQ_BIT=34, JDO_ERRCLR_BIT=35, JDO_WDATA_LSB=3
- DATA_W=32, BE_ALL=4'hF

One sub-module, ocimem_dbg_req_capture, holds:
- the strobe decode, priority and pending register (type and data)
- overrun/collision detection driving monitor_error

Test Plan:
- Address load, then read: take_action_ocimem_a with addr=8'h10, jdo[34]=1, RAM[0x10]=32'hDEADBEEF -> MonDReg=DEADBEEF and monitor_ready=1 two cycles after the strobe; MonAReg=0x11 (0x10 with OCIMEM_AUTOINC_EN off).
- Write at the top address: MonAReg=8'hFF, take_action_ocimem_b with data 32'h12345678 -> RAM[0xFF]=12345678 with be=F; MonAReg wraps to 0x00.
- Overrun: second strobe issued during DBG_RD_WAIT -> monitor_error=1, second op dropped. take_action_ocimem_a with jdo[35]=1 -> monitor_error=0.
- Arbitration: avs_read at 0x20 in the same cycle a debug write is pending -> debug write first; avs_waitrequest=1 for 1 cycle; CPU read completes 2 cycles later with the correct data.
- CPU byte write: avs_write to 0x05, be=4'b0010, data 32'h0000AB00 -> RAM byte 1 = AB, other bytes unchanged; waitrequest=0 in the same cycle.
- Reset mid-op: reset_n low during DBG_RD_WAIT -> all outputs at reset values, no further RAM access; after release, FSM in IDLE and accepts a new read.

Source files
------------

// File: rtl/niosii_cpu_ocimem_ctrl_pkg.sv
// rtl/niosii_cpu_ocimem_ctrl_pkg.sv - shared types and jdo field positions for the debug-memory controller
// Purpose: FSM state enum, jdo bit positions and data constants used by every
//          file of the OCI memory controller.
// Ports:   none (package).
package niosii_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DBG_RD_WAIT,
    CPU_RD_WAIT
  } ocimem_state_t;

  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_RDREQ_BIT  = 34;
  localparam int JDO_ERRCLR_BIT = 35;
  localparam int JDO_WDATA_LSB  = 3;

  localparam int         DATA_W = 32;
  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/niosii_cpu_ocimem_ctrl_if.sv
// rtl/niosii_cpu_ocimem_ctrl_if.sv - CPU-side Avalon-MM slave bus into the debug RAM
// Purpose: groups the CPU Avalon-MM request/response signals.
// Ports:   master modport drives address/read/write/writedata/byteenable and
//          receives readdata/waitrequest; slave modport is the reverse.
interface niosii_cpu_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  import niosii_ocimem_pkg::*;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );

endinterface

// File: rtl/niosii_cpu_ocimem_ctrl_dbg_req_capture.sv
// rtl/niosii_cpu_ocimem_ctrl_dbg_req_capture.sv - debug strobe decode, pending request and error flag
// Purpose: decodes the take_* strobes with priority a > b > no_action_a,
//          holds one pending debug op, and flags overrun/collision.
// Ports:   clk, reset_n; jdo and take_* strobes in; busy (op pending or read
//          in flight) and consume (pending op issued this cycle) from the FSM;
//          pend_valid/pend_wr/pend_wdata, addr_load/load_addr, op_queued and
//          monitor_error out.
module ocimem_dbg_req_capture
  import niosii_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              busy,
  input  logic              consume,
  output logic              pend_valid,
  output logic              pend_wr,
  output logic [DATA_W-1:0] pend_wdata,
  output logic              addr_load,
  output logic [ADDR_W-1:0] load_addr,
  output logic              op_queued,
  output logic              monitor_error
);

  logic sel_a, sel_b, sel_n, any_strobe, multi, accept;
  logic queue_rd, queue_wr, err_set, err_clr;
  logic unused_jdo_bits;

  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  assign sel_a      = take_action_ocimem_a;
  assign sel_b      = take_action_ocimem_b & ~take_action_ocimem_a;
  assign sel_n      = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi      = (take_action_ocimem_a & take_action_ocimem_b) |
                      (take_action_ocimem_a & take_no_action_ocimem_a) |
                      (take_action_ocimem_b & take_no_action_ocimem_a);

  // A busy controller drops the whole strobe, address load and error clear included.
  assign accept    = any_strobe & ~busy;
  assign addr_load = accept & sel_a;
  assign load_addr = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign queue_rd  = accept & ((sel_a & jdo[JDO_RDREQ_BIT]) | sel_n);
  assign queue_wr  = accept & sel_b;
  assign op_queued = queue_rd | queue_wr;

  // Setting wins over clearing when a collision carries an error-clear.
  assign err_set = (any_strobe & busy) | multi;
  assign err_clr = accept & sel_a & jdo[JDO_ERRCLR_BIT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid    <= 1'b0;
      pend_wr       <= 1'b0;
      pend_wdata    <= '0;
      monitor_error <= 1'b0;
    end else begin
      if (op_queued) begin
        pend_valid <= 1'b1;
        pend_wr    <= queue_wr;
        pend_wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      if (err_set)      monitor_error <= 1'b1;
      else if (err_clr) monitor_error <= 1'b0;
    end
  end

endmodule

// File: rtl/niosii_cpu_ocimem_ctrl.sv
// rtl/niosii_cpu_ocimem_ctrl.sv - debug RAM access controller with CPU Avalon-MM arbitration
// Purpose: executes debug reads/writes on the single-port debug RAM and
//          shares the RAM with a CPU Avalon-MM slave; debug always wins.
// Ports:   clk, reset_n; jdo + take_* strobes from the debug slave; avs
//          (Avalon-MM slave interface); ram_addr/ram_wr/ram_be/ram_wdata out
//          and ram_rdata in (1-cycle registered RAM); MonAReg, MonDReg,
//          monitor_ready, monitor_error back to the debug side.
// Build option: OCIMEM_AUTOINC_EN - MonAReg increments after each completed
//          debug read or write; otherwise only take_action_ocimem_a moves it.
module niosii_cpu_ocimem_ctrl
  import niosii_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [37:0]             jdo,
  input  logic                    take_action_ocimem_a,
  input  logic                    take_no_action_ocimem_a,
  input  logic                    take_action_ocimem_b,
  niosii_cpu_ocimem_ctrl_if.slave avs,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_wr,
  output logic [3:0]              ram_be,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic [ADDR_W-1:0]       MonAReg,
  output logic [DATA_W-1:0]       MonDReg,
  output logic                    monitor_ready,
  output logic                    monitor_error
);

  ocimem_state_t     state, state_n;
  logic              pend_valid, pend_wr, addr_load, op_queued;
  logic [DATA_W-1:0] pend_wdata;
  logic [ADDR_W-1:0] load_addr;
  logic              busy, consume, dbg_done, mon_inc;
  logic              ram_wr_c, wreq_c;

  assign busy    = pend_valid | (state == DBG_RD_WAIT);
  assign consume = (state == IDLE) & pend_valid;
  assign dbg_done = (consume & pend_wr) | (state == DBG_RD_WAIT);

`ifdef OCIMEM_AUTOINC_EN
  assign mon_inc = dbg_done;
`else
  assign mon_inc = 1'b0;
`endif

  ocimem_dbg_req_capture #(.ADDR_W(ADDR_W)) u_capture (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .busy                    (busy),
    .consume                 (consume),
    .pend_valid              (pend_valid),
    .pend_wr                 (pend_wr),
    .pend_wdata              (pend_wdata),
    .addr_load               (addr_load),
    .load_addr               (load_addr),
    .op_queued               (op_queued),
    .monitor_error           (monitor_error)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ram_addr  = avs.avs_address;
    ram_be    = avs.avs_byteenable;
    ram_wdata = avs.avs_writedata;
    ram_wr_c  = 1'b0;
    wreq_c    = 1'b1;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          ram_addr = MonAReg;
          if (pend_wr) begin
            ram_wr_c  = 1'b1;
            ram_be    = BE_ALL;
            ram_wdata = pend_wdata;
          end else begin
            state_n = DBG_RD_WAIT;
          end
        end else if (avs.avs_write) begin
          ram_wr_c = 1'b1;
          wreq_c   = 1'b0;
        end else if (avs.avs_read) begin
          state_n = CPU_RD_WAIT;
        end
      end
      DBG_RD_WAIT: begin
        ram_addr = MonAReg;
        state_n  = IDLE;
      end
      CPU_RD_WAIT: begin
        wreq_c  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Reset is asynchronous, so the bus outputs are gated directly by reset_n.
  assign ram_wr              = ram_wr_c & reset_n;
  assign avs.avs_waitrequest = wreq_c | ~reset_n;
  assign avs.avs_readdata    = ram_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
    end else begin
      if (addr_load)    MonAReg <= load_addr;
      else if (mon_inc) MonAReg <= MonAReg + 1'b1;
      if (state == DBG_RD_WAIT) MonDReg <= ram_rdata;
      if (op_queued)     monitor_ready <= 1'b0;
      else if (dbg_done) monitor_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_niosii_cpu_ocimem_ctrl.sv
// tb/tb_niosii_cpu_ocimem_ctrl.sv - self-checking bench for the debug-memory controller
module tb_niosii_cpu_ocimem_ctrl;

  localparam int AW = 8;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a, take_n, take_b;
  logic [AW-1:0] ram_addr;
  logic        ram_wr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [AW-1:0] MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  niosii_cpu_ocimem_ctrl_if #(.ADDR_W(AW)) avs_bus ();

  niosii_cpu_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_n),
    .take_action_ocimem_b    (take_b),
    .avs                     (avs_bus),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_be                  (ram_be),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonAReg                 (MonAReg),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, byte-enabled write, backdoor preload port.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [3:0]  last_be = '0;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_wr) begin
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      last_be  <= ram_be;
      wr_count <= wr_count + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_dbg_q[$];
  logic [31:0] exp_cpu_q[$];

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[17 +: 8] = a;
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  function automatic logic [7:0] exp_inc(input logic [7:0] a);
`ifdef OCIMEM_AUTOINC_EN
    return a + 8'd1;
`else
    return a;
`endif
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic strobe(input int kind, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    case (kind)
      0: take_a = 1'b1;
      1: take_b = 1'b1;
      default: take_n = 1'b1;
    endcase
    @(negedge clk);
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (monitor_ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    avs_bus.avs_write = 1'b1;
    avs_bus.avs_address = 8'h03;
    avs_bus.avs_byteenable = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (MonAReg !== 8'h00) begin errors++; $display("FAIL reset_MonAReg got=%h exp=00", MonAReg); end
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_MonDReg got=%h exp=0", MonDReg); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", monitor_ready); end
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", monitor_error); end
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got=%b exp=0", ram_wr); end
    checks++; if (avs_bus.avs_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq got=%b exp=1", avs_bus.avs_waitrequest); end
    avs_bus.avs_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL reset_no_write got=%0d exp=0", wr_count); end
  endtask

  task automatic test_addr_read();
    int n;
    logic [31:0] exp;
    preload(8'h10, 32'hDEADBEEF);
    exp_dbg_q.push_back(32'hDEADBEEF);
    strobe(0, jdo_a(8'h10, 1'b1, 1'b0));
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_cleared got=%b exp=0", monitor_ready); end
    checks++; if (MonAReg !== 8'h10) begin errors++; $display("FAIL rd_addr_load got=%h exp=10", MonAReg); end
    wait_ready(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", n); end
    checks++;
    if (exp_dbg_q.size() == 0) begin errors++; $display("FAIL rd_data scoreboard empty"); end
    else begin
      exp = exp_dbg_q.pop_front();
      if (MonDReg !== exp) begin errors++; $display("FAIL rd_data got=%h exp=%h", MonDReg, exp); end
    end
    checks++; if (MonAReg !== exp_inc(8'h10)) begin errors++; $display("FAIL rd_addr_after got=%h exp=%h", MonAReg, exp_inc(8'h10)); end
  endtask

  task automatic test_write_top();
    int n;
    preload(8'hFF, 32'h0);
    strobe(0, jdo_a(8'hFF, 1'b0, 1'b0));
    checks++; if (MonAReg !== 8'hFF) begin errors++; $display("FAIL wr_addr_load got=%h exp=FF", MonAReg); end
    checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_kept got=%b exp=1", monitor_ready); end
    strobe(1, jdo_b(32'h12345678));
    wait_ready(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL wr_latency got=%0d exp=1", n); end
    checks++; if (mem[8'hFF] !== 32'h12345678) begin errors++; $display("FAIL wr_data got=%h exp=12345678", mem[8'hFF]); end
    checks++; if (last_be !== 4'hF) begin errors++; $display("FAIL wr_be got=%h exp=F", last_be); end
    checks++; if (MonAReg !== exp_inc(8'hFF)) begin errors++; $display("FAIL wr_addr_wrap got=%h exp=%h", MonAReg, exp_inc(8'hFF)); end
  endtask

  task automatic test_overrun();
    int wc;
    logic [31:0] exp;
    preload(8'h30, 32'hA5A55A5A);
    exp_dbg_q.push_back(32'hA5A55A5A);
    @(negedge clk); jdo = jdo_a(8'h30, 1'b1, 1'b0); take_a = 1'b1;
    @(negedge clk); take_a = 1'b0;
    @(negedge clk); take_n = 1'b1;
    @(negedge clk); take_n = 1'b0;
    checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovr_error_set got=%b exp=1", monitor_error); end
    checks++;
    if (exp_dbg_q.size() == 0) begin errors++; $display("FAIL ovr_data scoreboard empty"); end
    else begin
      exp = exp_dbg_q.pop_front();
      if (MonDReg !== exp) begin errors++; $display("FAIL ovr_data got=%h exp=%h", MonDReg, exp); end
    end
    repeat (3) @(negedge clk);
    checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL ovr_dropped_ready got=%b exp=1", monitor_ready); end
    checks++; if (MonAReg !== exp_inc(8'h30)) begin errors++; $display("FAIL ovr_addr got=%h exp=%h", MonAReg, exp_inc(8'h30)); end
    strobe(0, jdo_a(8'h40, 1'b0, 1'b1));
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL ovr_error_clear got=%b exp=0", monitor_error); end
    checks++; if (MonAReg !== 8'h40) begin errors++; $display("FAIL ovr_clear_addr got=%h exp=40", MonAReg); end
    wc = wr_count;
    @(negedge clk); jdo = jdo_a(8'h42, 1'b0, 1'b0); take_a = 1'b1; take_b = 1'b1;
    @(negedge clk); take_a = 1'b0; take_b = 1'b0;
    checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL coll_error got=%b exp=1", monitor_error); end
    checks++; if (MonAReg !== 8'h42) begin errors++; $display("FAIL coll_a_wins got=%h exp=42", MonAReg); end
    repeat (3) @(negedge clk);
    checks++; if (wr_count !== wc) begin errors++; $display("FAIL coll_b_dropped got=%0d exp=%0d", wr_count, wc); end
    strobe(0, jdo_a(8'h42, 1'b0, 1'b1));
  endtask

  task automatic test_arbitration();
    int n;
    logic [31:0] exp;
    preload(8'h20, 32'hCAFEF00D);
    exp_cpu_q.push_back(32'hCAFEF00D);
    strobe(0, jdo_a(8'h50, 1'b0, 1'b0));
    @(negedge clk); jdo = jdo_b(32'h11112222); take_b = 1'b1;
    @(negedge clk); take_b = 1'b0;
    avs_bus.avs_read = 1'b1; avs_bus.avs_address = 8'h20;
    #1;
    checks++; if (avs_bus.avs_waitrequest !== 1'b1) begin errors++; $display("FAIL arb_stall got=%b exp=1", avs_bus.avs_waitrequest); end
    checks++; if (ram_wr !== 1'b1 || ram_addr !== 8'h50) begin errors++; $display("FAIL arb_dbg_first got wr=%b addr=%h exp wr=1 addr=50", ram_wr, ram_addr); end
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      if (!avs_bus.avs_waitrequest) begin
        n = i;
        break;
      end
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL arb_cpu_latency got=%0d exp=2", n); end
    checks++;
    if (exp_cpu_q.size() == 0) begin errors++; $display("FAIL arb_cpu_data scoreboard empty"); end
    else begin
      exp = exp_cpu_q.pop_front();
      if (avs_bus.avs_readdata !== exp) begin errors++; $display("FAIL arb_cpu_data got=%h exp=%h", avs_bus.avs_readdata, exp); end
    end
    avs_bus.avs_read = 1'b0;
    checks++; if (mem[8'h50] !== 32'h11112222) begin errors++; $display("FAIL arb_dbg_write got=%h exp=11112222", mem[8'h50]); end
  endtask

  task automatic test_cpu_byte_write();
    preload(8'h05, 32'h11223344);
    @(negedge clk);
    avs_bus.avs_write = 1'b1; avs_bus.avs_address = 8'h05;
    avs_bus.avs_byteenable = 4'b0010; avs_bus.avs_writedata = 32'h0000AB00;
    #1;
    checks++; if (avs_bus.avs_waitrequest !== 1'b0) begin errors++; $display("FAIL bw_waitreq got=%b exp=0", avs_bus.avs_waitrequest); end
    checks++; if (ram_wr !== 1'b1 || ram_be !== 4'b0010) begin errors++; $display("FAIL bw_strobe got wr=%b be=%b exp wr=1 be=0010", ram_wr, ram_be); end
    @(negedge clk);
    avs_bus.avs_write = 1'b0;
    checks++; if (mem[8'h05] !== 32'h1122AB44) begin errors++; $display("FAIL bw_data got=%h exp=1122AB44", mem[8'h05]); end
  endtask

  task automatic test_reset_midop();
    int wc, n;
    logic [31:0] exp;
    preload(8'h60, 32'h55AA55AA);
    wc = wr_count;
    @(negedge clk); jdo = jdo_a(8'h60, 1'b1, 1'b0); take_a = 1'b1;
    @(negedge clk); take_a = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    checks++; if (MonAReg !== 8'h00 || MonDReg !== 32'h0) begin errors++; $display("FAIL mid_regs got A=%h D=%h exp 00/0", MonAReg, MonDReg); end
    checks++; if (monitor_ready !== 1'b0 || monitor_error !== 1'b0) begin errors++; $display("FAIL mid_flags got r=%b e=%b exp 0/0", monitor_ready, monitor_error); end
    checks++; if (avs_bus.avs_waitrequest !== 1'b1 || ram_wr !== 1'b0) begin errors++; $display("FAIL mid_bus got wreq=%b wr=%b exp 1/0", avs_bus.avs_waitrequest, ram_wr); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (wr_count !== wc || MonDReg !== 32'h0) begin errors++; $display("FAIL mid_no_access got wr=%0d D=%h exp wr=%0d D=0", wr_count, MonDReg, wc); end
    preload(8'h61, 32'h0BADF00D);
    exp_dbg_q.push_back(32'h0BADF00D);
    strobe(0, jdo_a(8'h61, 1'b1, 1'b0));
    wait_ready(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL mid_new_latency got=%0d exp=2", n); end
    checks++;
    if (exp_dbg_q.size() == 0) begin errors++; $display("FAIL mid_new_data scoreboard empty"); end
    else begin
      exp = exp_dbg_q.pop_front();
      if (MonDReg !== exp) begin errors++; $display("FAIL mid_new_data got=%h exp=%h", MonDReg, exp); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
    avs_bus.avs_address = '0;
    avs_bus.avs_read = 1'b0;
    avs_bus.avs_write = 1'b0;
    avs_bus.avs_writedata = '0;
    avs_bus.avs_byteenable = '0;
    test_reset();
    test_addr_read();
    test_write_top();
    test_overrun();
    test_arbitration();
    test_cpu_byte_write();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
